sha256_block_engine: RTL

Iterative SHA-256 block processor: accepts one padded 512-bit message block plus a 256-bit chaining state, runs the 64 compression rounds through a single registered round stage (one round per clock), then adds the result into the chaining state. Sits between the miner's header/nonce scheduler (upstream) and the hash-compare stage (downstream). It is the sequencer for the round datapath: it owns the round counter, the round-constant ROM, the working-variable and message-schedule feedback registers, and the in/out handshakes.

---
 rtl/sha256_block_engine.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sha256_block_engine.sv
// Iterative SHA-256 compression: one round per clock over a registered working set,
// followed by the feed-forward add into the chaining state.
module sha256_block_engine #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] blockIn [0:15],
    input  logic [31:0] hashIn  [0:7],
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] hashOut [0:7],
    input  logic        abort,
    output logic        busy,
    output logic [5:0]  roundIdx
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state, stateNext;
    logic [31:0] w    [0:15];
    logic [31:0] hReg [0:7];
    logic [31:0] v    [0:7];
    logic [31:0] t1, t2, wNext;

    assign inReady = (state == IDLE) && !rst;
    assign busy    = (state != IDLE);

    always_comb begin
        t1    = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[roundIdx] + w[0];
        t2    = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        wNext = w[0] + ssig0(w[1]) + w[9] + ssig1(w[14]);
    end

    always_comb begin
        stateNext = state;
        if (abort) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (inValid) stateNext = ROUND;
                ROUND:   if (roundIdx == LAST_ROUND) stateNext = FINAL;
                FINAL:   stateNext = DONE;
                DONE:    if (outReady) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            roundIdx <= '0;
            hashOut  <= '{default: '0};
        end else if (abort) begin
            outValid <= 1'b0;
            roundIdx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        w        <= blockIn;
                        hReg     <= hashIn;
                        v        <= hashIn;
                        roundIdx <= '0;
                    end
                end
                ROUND: begin
                    // w[0] always holds the schedule word for the current round
                    for (int unsigned i = 0; i < 15; i++) w[i] <= w[i + 1];
                    w[15]    <= wNext;
                    v[0]     <= t1 + t2;
                    v[1]     <= v[0];
                    v[2]     <= v[1];
                    v[3]     <= v[2];
                    v[4]     <= v[3] + t1;
                    v[5]     <= v[4];
                    v[6]     <= v[5];
                    v[7]     <= v[6];
                    roundIdx <= roundIdx + 1'b1;
                end
                FINAL: begin
                    for (int unsigned i = 0; i < 8; i++) hashOut[i] <= hReg[i] + v[i];
                    outValid <= 1'b1;
                end
                DONE: begin
                    if (outReady) outValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
